regfile_wr_arbiter: RTL and testbench

Write-side controller for the 16-entry x 16-bit register file. It shares the file's single write port between two requesters (A, B) using a valid/ready handshake and round-robin arbitration. It also runs a clear sweep that writes zero to every entry after reset or on request. It sits between the producers and the register file's `en`/`wr_addr`/`wr_data` inputs; the read ports are untouched.

---
 rtl/regfile_wr_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-side controller for the register file: round-robin arbitration of two
// valid/ready requesters onto the single write port, plus a zero-fill clear sweep.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_nxt;
  logic              r_prio;
  logic              w_prio_nxt;

  // State register; r_prio = 1 means B wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_clr_cnt <= '0;
      r_prio    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_prio    <= w_prio_nxt;
    end
  end

  // Next-state and write-port decode; grants are combinational for zero-latency writes.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_prio_nxt    = r_prio;
    a_ready       = 1'b0;
    b_ready       = 1'b0;
    rf_en         = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    busy          = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_clr_cnt_nxt = '0;
        w_state_nxt   = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
      end

      S_CLEAR: begin
        rf_en         = 1'b1;
        rf_wr_addr    = r_clr_cnt;
        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        busy    = 1'b0;
        a_ready = a_valid & (~b_valid | ~r_prio);
        b_ready = b_valid & (~a_valid | r_prio);
        if (a_ready) begin
          rf_en      = 1'b1;
          rf_wr_addr = a_addr;
          rf_wr_data = a_data;
          w_prio_nxt = 1'b1;
        end else if (b_ready) begin
          rf_en      = 1'b1;
          rf_wr_addr = b_addr;
          rf_wr_data = b_data;
          w_prio_nxt = 1'b0;
        end
        // The grant above still completes in the same cycle as a clear request.
        if (clr_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a queue-based behavioural model
// of the clear sweep and round-robin arbitration, with the directed scenarios inline.
module tb_regfile_wr_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam bit          CLR_RST = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_req;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic              rf_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              busy;

  regfile_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLR_RST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_en(rf_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: pending startup cycle, queue of remaining sweep addresses,
  // and which requester wins the next tie.
  bit   m_idle;
  int   m_sweep[$];
  int   m_favor;
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] dut_mem [DEPTH];
  logic s_ar, s_br;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle  = 1'b1;
    m_sweep.delete();
    m_favor = 0;
  endtask

  task automatic fill_sweep();
    m_sweep.delete();
    for (int i = 0; i < int'(DEPTH); i++) m_sweep.push_back(i);
  endtask

  // Called at a falling edge: apply inputs, check outputs, advance model, go to next falling edge.
  task automatic cycle(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                       input logic cr);
    logic              e_en, e_ar, e_br, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    int                win;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    clr_req = cr;
    #1;
    e_en = 1'b0; e_ar = 1'b0; e_br = 1'b0; e_busy = 1'b1; e_addr = '0; e_data = '0;
    if (m_idle) begin
      m_idle = 1'b0;
      if (CLR_RST) fill_sweep();
    end else if (m_sweep.size() != 0) begin
      e_en   = 1'b1;
      e_addr = ADDR_W'(m_sweep.pop_front());
    end else begin
      e_busy = 1'b0;
      win = -1;
      if (av && bv) win = m_favor;
      else if (av)  win = 0;
      else if (bv)  win = 1;
      if (win == 0) begin
        e_ar = 1'b1; e_en = 1'b1; e_addr = aa; e_data = ad; m_favor = 1;
      end else if (win == 1) begin
        e_br = 1'b1; e_en = 1'b1; e_addr = ba; e_data = bd; m_favor = 0;
      end
      if (cr) fill_sweep();
    end
    chk("a_ready", 32'(a_ready), 32'(e_ar));
    chk("b_ready", 32'(b_ready), 32'(e_br));
    chk("busy",    32'(busy),    32'(e_busy));
    chk("rf_en",   32'(rf_en),   32'(e_en));
    chk("rf_addr", 32'(rf_wr_addr), 32'(e_addr));
    chk("rf_data", 32'(rf_wr_data), 32'(e_data));
    s_ar = a_ready;
    s_br = b_ready;
    if (e_en) exp_mem[e_addr] = e_data;
    if (rf_en) dut_mem[rf_wr_addr] = rf_wr_data;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Startup after reset release: one IDLE cycle, 16 sweep writes, then RUN.
  task automatic startup_check(input string tag);
    for (int k = 0; k <= int'(DEPTH); k++) begin
      if (k == 0) chk({tag, "_c0_en"}, 32'(rf_en), 32'h0);
      else        chk({tag, "_addr"}, 32'(rf_wr_addr), 32'(k - 1));
      idle_cycle();
    end
    #1;
    chk({tag, "_run_busy"}, 32'(busy), 32'h0);
  endtask

  logic              r_av, r_bv, r_cr;
  logic [ADDR_W-1:0] r_aa, r_ba;
  logic [DATA_W-1:0] r_ad, r_bd;
  logic              pat [4];

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    s_ar = 1'b0; s_br = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin exp_mem[i] = '0; dut_mem[i] = '0; end
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_en",   32'(rf_en), 32'h0);
    rst_n = 1'b1;
    startup_check("sweep");

    // Contention straight after reset: A, B, A, B.
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, ADDR_W'(1), 16'h1111, 1'b1, ADDR_W'(2), 16'h2222, 1'b0);
      chk("cont_a", 32'(s_ar), 32'(pat[i]));
      chk("cont_one", 32'(s_ar ^ s_br), 32'h1);
    end

    // B alone, then a tie: A must win.
    cycle(1'b0, '0, '0, 1'b1, ADDR_W'(3), 16'h3333, 1'b0);
    chk("solo_b", 32'(s_br), 32'h1);
    cycle(1'b1, ADDR_W'(4), 16'h4444, 1'b1, ADDR_W'(6), 16'h6666, 1'b0);
    chk("prio_a", 32'(s_ar), 32'h1);
    cycle(1'b0, '0, '0, 1'b1, ADDR_W'(6), 16'h6666, 1'b0);

    // Single requester, zero-latency write, visible next cycle.
    cycle(1'b1, ADDR_W'(5), 16'hBEEF, 1'b0, '0, '0, 1'b0);
    chk("single_rdy", 32'(s_ar), 32'h1);
    idle_cycle();
    chk("rd5", 32'(dut_mem[5]), 32'hBEEF);

    // Clear request together with a grant; A held through the sweep.
    cycle(1'b1, ADDR_W'(9), 16'hA5A5, 1'b0, '0, '0, 1'b1);
    chk("clr_grant", 32'(s_ar), 32'h1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      #1;
      chk("clr_addr", 32'(rf_wr_addr), 32'(i));
      cycle(1'b1, ADDR_W'(9), 16'h5A5A, 1'b0, '0, '0, 1'b0);
      chk("clr_blk", 32'(s_ar), 32'h0);
    end
    cycle(1'b1, ADDR_W'(9), 16'h5A5A, 1'b0, '0, '0, 1'b0);
    chk("clr_resume", 32'(s_ar), 32'h1);

    // Randomized traffic honouring the hold-until-ready contract.
    r_av = 1'b0; r_bv = 1'b0; r_aa = '0; r_ba = '0; r_ad = '0; r_bd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!r_av || s_ar) begin
        r_av = ($urandom % 3) != 0; r_aa = ADDR_W'($urandom); r_ad = DATA_W'($urandom);
      end
      if (!r_bv || s_br) begin
        r_bv = ($urandom % 3) != 0; r_ba = ADDR_W'($urandom); r_bd = DATA_W'($urandom);
      end
      r_cr = ($urandom % 50) == 0;
      cycle(r_av, r_aa, r_ad, r_bv, r_ba, r_bd, r_cr);
    end

    // Reach RUN, start a sweep, then reset at clr_cnt = 7.
    for (int n = 0; n < 40 && (m_idle || m_sweep.size() != 0); n++) idle_cycle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 7; i++) idle_cycle();
    #1;
    chk("mid_addr7", 32'(rf_wr_addr), 32'h7);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en",   32'(rf_en), 32'h0);
    chk("mid_rst_busy", 32'(busy),  32'h1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    startup_check("resweep");
    cycle(1'b1, ADDR_W'(2), 16'h0F0F, 1'b1, ADDR_W'(3), 16'hF0F0, 1'b0);
    chk("post_rst_prio", 32'(s_ar), 32'h1);

    for (int i = 0; i < int'(DEPTH); i++) chk("mem", 32'(dut_mem[i]), 32'(exp_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
